// File: rtl/alu_seq.sv
// alu_seq: sequences requests to an external ALU; the divide-wait timeout is built only with ALU_TIMEOUT_EN
module alu_seq #(
    parameter int N              = 32,
    parameter int ALU_OP_COUNT   = 4,
    parameter int FLAGS_COUNT    = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ALU_OP_COUNT-1:0] req_op,
    input  logic [N-1:0]            req_a,
    input  logic [N-1:0]            req_b,
    input  logic                    req_uns,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_result,
    output logic [N-1:0]            rsp_high,
    output logic [FLAGS_COUNT-1:0]  rsp_flags,
    output logic                    rsp_err,
    output logic [N-1:0]            alu_a,
    output logic [N-1:0]            alu_b,
    output logic [ALU_OP_COUNT-1:0] alu_opcode,
    output logic                    alu_uns,
    output logic                    alu_start,
    input  logic [N-1:0]            alu_result,
    input  logic [N-1:0]            alu_high,
    input  logic [FLAGS_COUNT-1:0]  alu_flags,
    input  logic                    alu_finished
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, DSTART, DWAIT, RESP} state_t;
    localparam logic [ALU_OP_COUNT-1:0] OP_ADD = ALU_OP_COUNT'(1);
    localparam logic [ALU_OP_COUNT-1:0] OP_MUL = ALU_OP_COUNT'(3);
    localparam logic [ALU_OP_COUNT-1:0] OP_DIV = ALU_OP_COUNT'(4);
    localparam logic [ALU_OP_COUNT-1:0] OP_NEG = ALU_OP_COUNT'(11);
    state_t                  state, next;
    logic [ALU_OP_COUNT-1:0] op_q;
    logic [N-1:0]            a_q, b_q, res_q, high_q;
    logic [FLAGS_COUNT-1:0]  flags_q;
    logic                    uns_q, err_q, first_q;
    logic                    legal, accept, done, tmo;
    assign legal  = (req_op >= OP_ADD) && (req_op <= OP_NEG);
    assign accept = (state == IDLE) && req_valid;
    // the first DWAIT cycle may still see a finished flag left over from an earlier operation
    assign done   = (state == DWAIT) && !first_q && alu_finished;
`ifdef ALU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    assign tmo = (state == DWAIT) && !done && (cnt == TMAX);
    // counts cycles spent in DWAIT, cleared everywhere else
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (state == DWAIT) ? cnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif
    // state register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !req_valid ? IDLE : !legal ? RESP : (req_op == OP_DIV) ? DSTART : ISSUE;
            ISSUE:   next = CAPTURE;
            CAPTURE: next = RESP;
            DSTART:  next = DWAIT;
            DWAIT:   next = (done || tmo) ? RESP : DWAIT;
            RESP:    next = rsp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end
    // outputs decoded from state; the ALU sees the opcode only while an operation is in flight
    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        rsp_valid  = (state == RESP);
        alu_start  = (state == DSTART);
        alu_opcode = (state == ISSUE || state == CAPTURE || state == DSTART || state == DWAIT) ? op_q : '0;
    end
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_uns    = uns_q;
    assign rsp_result = res_q;
    assign rsp_high   = high_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    // request registers and captured response; accept clears the response so errors report zeros
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            res_q   <= '0;
            high_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                uns_q   <= req_uns;
                res_q   <= '0;
                high_q  <= '0;
                flags_q <= '0;
                err_q   <= !legal;
            end
            if (state == CAPTURE) begin
                res_q   <= alu_result;
                high_q  <= (op_q == OP_MUL) ? alu_high : '0;
                flags_q <= alu_flags;
            end
            if (done) begin
                res_q   <= alu_result;
                high_q  <= alu_high;
                flags_q <= alu_flags;
            end
            if (tmo) err_q <= 1'b1;
            first_q <= (state == DSTART);
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against a behavioural ALU, checked by a queue scoreboard
module tb_alu_seq;
    typedef struct {
        logic [31:0] res;
        logic [31:0] high;
        logic [4:0]  fl;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    logic        CLK = 0, rst = 1;
    logic        req_valid = 0, req_uns = 0, rsp_ready = 1;
    logic [3:0]  req_op = 0;
    logic [31:0] req_a = 0, req_b = 0;
    logic        req_ready, rsp_valid, rsp_err, alu_uns, alu_start;
    logic [31:0] rsp_result, rsp_high, alu_a, alu_b;
    logic [4:0]  rsp_flags, alu_flags;
    logic [3:0]  alu_opcode;
    logic [31:0] m_res, m_high;
    logic [63:0] prod;
    logic        fin, busy;
    int          mcnt, model_lat = 2;
    int          cyc = 0, vstart = 0, start_cnt = 0, opc_cnt = 0;
    logic        prev_v = 0;
    int          checks = 0, fails = 0;
    exp_t        sb[$];

    alu_seq dut (
        .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_uns(req_uns), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_high(rsp_high), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_uns(alu_uns), .alu_start(alu_start),
        .alu_result(m_res), .alu_high(m_high), .alu_flags(alu_flags), .alu_finished(fin)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // behavioural ALU; junk on high/result where the sequencer must not use them
    assign prod = {32'b0, alu_a} * {32'b0, alu_b};
    always_comb begin
        m_res  = 32'hDEADBEEF;
        m_high = 32'hA5A5A5A5;
        case (alu_opcode)
            4'd1:  m_res = alu_a + alu_b;
            4'd2:  m_res = alu_a - alu_b;
            4'd3:  begin m_res = prod[31:0]; m_high = prod[63:32]; end
            4'd4:  if (fin) begin
                       m_res  = (alu_b != 0) ? alu_a / alu_b : 32'd0;
                       m_high = (alu_b != 0) ? alu_a % alu_b : 32'd0;
                   end
            4'd5:  m_res = alu_a & alu_b;
            4'd6:  m_res = alu_a | alu_b;
            4'd7:  m_res = alu_a ^ alu_b;
            4'd8:  m_res = ~alu_a;
            4'd9:  m_res = alu_a << alu_b[4:0];
            4'd10: m_res = alu_a >> alu_b[4:0];
            4'd11: m_res = -alu_a;
            default: ;
        endcase
    end
    assign alu_flags = {3'b0, m_res[31], m_res == 32'd0};

    // divider: finished stays high after completion and only drops a cycle after the next start
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            busy <= 0; fin <= 0; mcnt <= 0;
        end else if (alu_start) begin
            busy <= 1; mcnt <= model_lat;
        end else if (busy) begin
            if (mcnt == 0) begin fin <= 1; busy <= 0; end
            else begin fin <= 0; mcnt <= mcnt - 1; end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // monitor: pops the scoreboard at each response handshake
    always @(negedge CLK) begin
        exp_t e;
        if (alu_start) start_cnt++;
        if (alu_opcode != 0) opc_cnt++;
        if (rsp_valid && !prev_v) vstart = cyc;
        prev_v = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_rsp result=%h err=%b", rsp_result, rsp_err);
            end else begin
                e = sb.pop_front();
                chk("result", rsp_result, e.res);
                chk("high", rsp_high, e.high);
                chk("flags", 32'(rsp_flags), 32'(e.fl));
                chk("err", 32'(rsp_err), 32'(e.err));
                chk("latency", vstart - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic uns,
                         input logic push, input exp_t e);
        int w = 0;
        @(negedge CLK);
        while (!req_ready && w < 100) begin @(negedge CLK); w++; end
        if (!req_ready) begin
            checks++; fails++;
            $display("FAIL req_ready_timeout op=%0d", op);
            return;
        end
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_uns = uns;
        e.acc = cyc;
        if (push) sb.push_back(e);
        @(posedge CLK);
        #1 req_valid = 0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 400) begin @(negedge CLK); w++; end
        if (sb.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, b, res, high,
                       input logic [4:0] fl, input logic err, input int lat);
        int s0 = start_cnt;
        exp_t e = '{res, high, fl, err, lat, 0};
        issue(op, a, b, 1'b0, 1'b1, e);
        drain();
        chk("alu_start_pulses", start_cnt - s0, (op == 4'd4) ? 1 : 0);
    endtask

    task automatic do_reset();
        #2 rst = 1;
        repeat (2) @(negedge CLK);
        rst = 0;
    endtask

    initial begin
        exp_t e;
        int o0, w;
        #3;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_start", 32'(alu_start), 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        chk("rst_rsp_result", rsp_result, 0);
        repeat (2) @(negedge CLK);
        rst = 0;
        #1 chk("idle_req_ready", 32'(req_ready), 1);

        run(4'd1, 32'd5, 32'd3, 32'd8, 0, 5'b00000, 0, 3);
        run(4'd2, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 5'b00010, 0, 3);
        run(4'd3, 32'h00010000, 32'h00010000, 0, 32'd1, 5'b00001, 0, 3);
        run(4'd4, 32'd100, 32'd7, 32'd14, 32'd2, 5'b00000, 0, 6);
        run(4'd3, 32'd3, 32'd4, 32'd12, 0, 5'b00000, 0, 3);
        run(4'd4, 32'd20, 32'd6, 32'd3, 32'd2, 5'b00000, 0, 6);
        run(4'd5, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 0, 5'b00000, 0, 3);
        run(4'd6, 32'd1, 32'd2, 32'd3, 0, 5'b00000, 0, 3);
        run(4'd7, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 0, 5'b00000, 0, 3);
        run(4'd8, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 5'b00010, 0, 3);
        run(4'd9, 32'd1, 32'd4, 32'd16, 0, 5'b00000, 0, 3);
        run(4'd10, 32'h80000000, 32'd31, 32'd1, 0, 5'b00000, 0, 3);
        run(4'd11, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 5'b00010, 0, 3);

        o0 = opc_cnt;
        run(4'd12, 32'd9, 32'd9, 0, 0, 5'b00000, 1, 1);
        run(4'd0, 32'd9, 32'd9, 0, 0, 5'b00000, 1, 1);
        run(4'd15, 32'd9, 32'd9, 0, 0, 5'b00000, 1, 1);
        chk("illegal_alu_opcode_seen", opc_cnt - o0, 0);

        rsp_ready = 0;
        e = '{32'd15, 0, 5'b00000, 0, 3, 0};
        issue(4'd1, 32'd7, 32'd8, 1'b0, 1'b1, e);
        w = 0;
        while (!rsp_valid && w < 20) begin @(negedge CLK); w++; end
        repeat (5) begin
            @(negedge CLK);
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_result", rsp_result, 32'd15);
            chk("stall_req_ready", 32'(req_ready), 0);
        end
        @(posedge CLK);
        #1 rsp_ready = 1;
        drain();
        @(negedge CLK);
        chk("post_hs_req_ready", 32'(req_ready), 1);
        chk("post_hs_rsp_valid", 32'(rsp_valid), 0);

        issue(4'd4, 32'd50, 32'd5, 1'b1, 1'b0, e);
        chk("dstart_alu_start", 32'(alu_start), 1);
        chk("dstart_alu_uns", 32'(alu_uns), 1);
        chk("dstart_alu_a", alu_a, 32'd50);
        #2 rst = 1;
        #1;
        chk("async_rst_alu_start", 32'(alu_start), 0);
        chk("async_rst_alu_opcode", 32'(alu_opcode), 0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rst_alu_a", alu_a, 0);
        repeat (2) @(negedge CLK);
        rst = 0;
        run(4'd1, 32'd5, 32'd3, 32'd8, 0, 5'b00000, 0, 3);

        model_lat = 1000;
`ifdef ALU_TIMEOUT_EN
        run(4'd4, 32'd100, 32'd7, 0, 0, 5'b00000, 1, 66);
`else
        issue(4'd4, 32'd100, 32'd7, 1'b0, 1'b0, e);
        repeat (200) @(negedge CLK);
        chk("hang_rsp_valid", 32'(rsp_valid), 0);
        chk("hang_alu_opcode", 32'(alu_opcode), 32'd4);
`endif
        do_reset();
        model_lat = 2;
        run(4'd4, 32'd9, 32'd4, 32'd2, 32'd1, 5'b00000, 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters SHALL be: N, 32, operand/result width; ALU_OP_COUNT, 4, opcode width; FLAGS_COUNT, 5, flags width; TIMEOUT_CYCLES, 64, divide-wait limit (used only with ALU_TIMEOUT_EN).
REQ-002 Ports SHALL be, one per line:
  CLK  in  1  clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  req_valid  in  1  request present
  req_ready  out  1  request accepted when high with req_valid
  req_op  in  ALU_OP_COUNT  operation code
  req_a, req_b  in  N  operands
  req_uns  in  1  unsigned operation
  rsp_valid  out  1  response present
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_result, rsp_high  out  N  low result; MUL upper word / DIV remainder
  rsp_flags  out  FLAGS_COUNT  ALU flags captured with result
  rsp_err  out  1  illegal opcode or timeout
  alu_a, alu_b  out  N  to ALU operands
  alu_opcode  out  ALU_OP_COUNT  to ALU opcode
  alu_uns, alu_start  out  1  to ALU uns / start
  alu_result, alu_high  in  N  from ALU
  alu_flags  in  FLAGS_COUNT  from ALU
  alu_finished  in  1  from ALU

Function
REQ-003 Opcodes SHALL be: ADD 1, SUB 2, MUL 3, DIV 4, AND 5, OR 6, XOR 7, INV 8, SHL 9, SHR 10, NEG 11; 0 and 12-15 illegal.
REQ-004 States SHALL be IDLE, ISSUE, CAPTURE, DSTART, DWAIT, RESP.
REQ-005 req_ready SHALL be high only in IDLE; an accepted request SHALL register op, a, b, uns.
REQ-006 IDLE -> ISSUE on accept of legal non-DIV op; IDLE -> DSTART on DIV; IDLE -> RESP on illegal op with rsp_err=1, rsp_result=0, rsp_high=0, rsp_flags=0.
REQ-007 alu_opcode SHALL be 0 in IDLE and RESP, and the registered op in ISSUE, CAPTURE, DSTART, DWAIT; alu_a/alu_b/alu_uns SHALL hold registered values throughout.
REQ-008 ISSUE SHALL last one cycle; CAPTURE SHALL sample alu_result, alu_high, alu_flags at its end and go to RESP; accept at cycle 0 gives rsp_valid at cycle 3.
REQ-009 For ops other than MUL/DIV, rsp_high SHALL be 0.
REQ-010 DSTART SHALL drive alu_start=1 for exactly one cycle; alu_start SHALL be 0 in every other state.
REQ-011 DWAIT SHALL ignore alu_finished in its first cycle (stale value), then capture outputs and go to RESP in the cycle alu_finished=1.
REQ-012 In RESP, rsp_valid=1 and rsp_* SHALL stay stable until rsp_ready=1, then next state IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-013 rsp_err SHALL be 0 for all normally completed operations.

Reset
REQ-014 rst=1 SHALL immediately force IDLE and zero all outputs and internal registers, including alu_start, alu_opcode, rsp_valid.
REQ-015 Reset during DSTART/DWAIT SHALL abandon the operation with no response; first post-reset request SHALL behave as after power-up.

Configuration
REQ-016 Macro ALU_TIMEOUT_EN defined: DWAIT SHALL count cycles; if alu_finished not seen within TIMEOUT_CYCLES cycles of entering DWAIT, go to RESP with rsp_err=1 and result/high/flags 0.
REQ-017 Macro ALU_TIMEOUT_EN undefined: no counter SHALL exist; DWAIT waits indefinitely and rsp_err flags only illegal opcodes.

Verification
REQ-018 ADD a=5 b=3, rsp_ready=1 -> rsp_valid at cycle 3, rsp_result=8, rsp_high=0, rsp_err=0, flags from ALU model.
REQ-019 MUL a=0x00010000 b=0x00010000 -> rsp_result=0, rsp_high=1; DIV a=100 b=7 -> alu_start one cycle, rsp_result=14, rsp_high=2.
REQ-020 DIV with alu_finished held 1 from prior MUL -> first DWAIT cycle ignored, result taken only after ALU finished pulse.
REQ-021 rsp_ready low for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout, IDLE one cycle after handshake.
REQ-022 req_op=12 -> rsp_valid at cycle 1, rsp_err=1, alu_opcode never nonzero; rst asserted mid-DWAIT -> alu_start, rsp_valid 0 same cycle, no response.
REQ-023 With ALU_TIMEOUT_EN, DIV, alu_finished held 0 -> rsp_err=1 after 64 DWAIT cycles; without macro, no response after 200 cycles.
